// File: rtl/alu_shift_pipe.sv
// Two-stage pipelined ARM barrel shifter + ALU with an NZCV flag register and valid/ready handshakes.
// Optional feature macro: ALU_SHIFT_PIPE_CF_FWD_EN forwards the stage-1 carry instead of stalling.
module alu_shift_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_data,
    input  logic [7:0]       in_amt,
    input  logic [2:0]       in_shft_op,
    input  logic [3:0]       in_alu_op,
    input  logic             in_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_f,
    output logic [3:0]       out_nzcv,
    output logic             out_wr,
    output logic [3:0]       flags
);
    // Handshake rule: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and the payload is held while valid && !ready.
    localparam int LW = $clog2(WIDTH);
    localparam logic [7:0] W8 = 8'(WIDTH);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_sc;
    logic [3:0]       s1_op;
    logic             s1_s;

    logic s2_en, s1_adv, in_fire, hazard, s1_sets, cf_in;

    logic [WIDTH-1:0] alu_x, alu_y, alu_f;
    logic             alu_ci, alu_arith, alu_c, alu_v;
    logic [WIDTH:0]   alu_sum;
    logic [3:0]       alu_nzcv;

    logic [WIDTH-1:0]        sh_out, rot;
    logic                    sh_c;
    logic [WIDTH:0]          ext_l, ext_r;
    logic signed [WIDTH:0]   ext_a;

    // TST TEQ CMP CMN (8..B) always update flags and never write back.
    assign s1_sets = s1_s || (s1_op[3:2] == 2'b10);
    assign s2_en   = !out_valid || out_ready;
    assign s1_adv  = s1_valid && s2_en;
    assign in_ready = (!s1_valid || s2_en) && !hazard;
    assign in_fire  = in_valid && in_ready;

`ifdef ALU_SHIFT_PIPE_CF_FWD_EN
    assign cf_in  = (s1_valid && s1_sets) ? alu_c : flags[1];
    assign hazard = 1'b0;
`else
    logic uses_cf;
    assign cf_in   = flags[1];
    assign uses_cf = (in_shft_op >= 3'd4) || (in_amt == 8'd0);
    assign hazard  = s1_valid && s1_sets && uses_cf;
`endif

    always_comb begin
        sh_out = in_data;
        sh_c   = cf_in;
        ext_l  = {1'b0, in_data} << in_amt;
        ext_r  = {in_data, 1'b0} >> in_amt;
        ext_a  = $signed({in_data, 1'b0}) >>> in_amt;
        rot    = WIDTH'({in_data, in_data} >> in_amt[LW-1:0]);
        case (in_shft_op)
            3'd0: if (in_amt != 8'd0) begin
                if (in_amt <= W8) begin
                    sh_out = ext_l[WIDTH-1:0];
                    sh_c   = ext_l[WIDTH];
                end else begin
                    sh_out = '0;
                    sh_c   = 1'b0;
                end
            end
            3'd1: if (in_amt != 8'd0) begin
                if (in_amt <= W8) begin
                    sh_out = ext_r[WIDTH:1];
                    sh_c   = ext_r[0];
                end else begin
                    sh_out = '0;
                    sh_c   = 1'b0;
                end
            end
            3'd2: if (in_amt != 8'd0) begin
                if (in_amt < W8) begin
                    sh_out = ext_a[WIDTH:1];
                    sh_c   = ext_a[0];
                end else begin
                    sh_out = {WIDTH{in_data[WIDTH-1]}};
                    sh_c   = in_data[WIDTH-1];
                end
            end
            // A rotate by a multiple of WIDTH leaves data intact; carry is still its MSB.
            3'd3: if (in_amt != 8'd0) begin
                sh_out = rot;
                sh_c   = rot[WIDTH-1];
            end
            3'd4: begin
                sh_out = {cf_in, in_data[WIDTH-1:1]};
                sh_c   = in_data[0];
            end
            default: ;
        endcase
    end

    // Subtract-type ops are folded into x + ~y + cin so C is already NOT borrow.
    always_comb begin
        alu_x     = s1_a;
        alu_y     = s1_b;
        alu_ci    = 1'b0;
        alu_arith = 1'b0;
        case (s1_op)
            4'h2, 4'hA: begin alu_y = ~s1_b; alu_ci = 1'b1; alu_arith = 1'b1; end
            4'h3:       begin alu_x = s1_b; alu_y = ~s1_a; alu_ci = 1'b1; alu_arith = 1'b1; end
            4'h4, 4'hB: begin alu_arith = 1'b1; end
            4'h5:       begin alu_ci = flags[1]; alu_arith = 1'b1; end
            4'h6:       begin alu_y = ~s1_b; alu_ci = flags[1]; alu_arith = 1'b1; end
            4'h7:       begin alu_x = s1_b; alu_y = ~s1_a; alu_ci = flags[1]; alu_arith = 1'b1; end
            default: ;
        endcase
        alu_sum = {1'b0, alu_x} + {1'b0, alu_y} + {{WIDTH{1'b0}}, alu_ci};
        case (s1_op)
            4'h0, 4'h8: alu_f = s1_a & s1_b;
            4'h1, 4'h9: alu_f = s1_a ^ s1_b;
            4'hC:       alu_f = s1_a | s1_b;
            4'hD:       alu_f = s1_b;
            4'hE:       alu_f = s1_a & ~s1_b;
            4'hF:       alu_f = ~s1_b;
            default:    alu_f = alu_sum[WIDTH-1:0];
        endcase
        alu_c = alu_arith ? alu_sum[WIDTH] : s1_sc;
        alu_v = alu_arith ? ((alu_x[WIDTH-1] == alu_y[WIDTH-1]) && (alu_f[WIDTH-1] != alu_x[WIDTH-1]))
                          : flags[0];
        alu_nzcv = {alu_f[WIDTH-1], (alu_f == '0), alu_c, alu_v};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_sc     <= 1'b0;
            s1_op     <= '0;
            s1_s      <= 1'b0;
            out_valid <= 1'b0;
            out_f     <= '0;
            out_nzcv  <= '0;
            out_wr    <= 1'b0;
            flags     <= '0;
        end else begin
            if (s1_adv) s1_valid <= 1'b0;
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_a     <= in_a;
                s1_b     <= sh_out;
                s1_sc    <= sh_c;
                s1_op    <= in_alu_op;
                s1_s     <= in_s;
            end
            // Flags commit on the same edge the op lands in stage 2.
            if (s2_en) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_f    <= alu_f;
                    out_nzcv <= s1_sets ? alu_nzcv : flags;
                    out_wr   <= (s1_op[3:2] != 2'b10);
                    if (s1_sets) flags <= alu_nzcv;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_shift_pipe.sv
// Self-checking bench for alu_shift_pipe: directed vector table, hazard/backpressure/reset
// sequences, and randomized traffic against a sequential reference model.
module tb_alu_shift_pipe;
    localparam int W = 32;
    localparam longint SMAX = 64'sh7fffffff;
    localparam longint SMIN = -64'sh80000000;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_s, out_valid, out_ready, out_wr;
    logic [W-1:0] in_a, in_data, out_f;
    logic [7:0]   in_amt;
    logic [2:0]   in_shft_op;
    logic [3:0]   in_alu_op, out_nzcv, flags;

    alu_shift_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_data(in_data), .in_amt(in_amt),
        .in_shft_op(in_shft_op), .in_alu_op(in_alu_op), .in_s(in_s),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_f(out_f), .out_nzcv(out_nzcv), .out_wr(out_wr), .flags(flags)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] data;
        logic [7:0]  amt;
        logic [2:0]  sh;
        logic [3:0]  alu;
        logic        s;
    } op_t;

    typedef struct packed {
        logic [31:0] f;
        logic [3:0]  nzcv;
        logic        wr;
    } res_t;

    typedef struct packed {
        op_t         op;
        logic [31:0] f;
        logic [3:0]  nzcv;
        logic        wr;
    } vec_t;

    res_t        exp_q[$];
    logic [3:0]  m_flags;
    logic [31:0] last_f;
    logic [3:0]  last_nzcv;
    logic        last_wr;
    int          n_checks = 0;
    int          n_fail = 0;
    vec_t        tbl[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic op_t mk(input logic [31:0] a, input logic [31:0] d, input logic [7:0] amt,
                               input logic [2:0] sh, input logic [3:0] alu, input logic s);
        op_t o;
        o.a = a; o.data = d; o.amt = amt; o.sh = sh; o.alu = alu; o.s = s;
        return o;
    endfunction

    function automatic void arith(input logic [31:0] x, input logic [31:0] y, input logic ci,
                                  input bit is_sub, output logic [31:0] f, output logic c,
                                  output logic v);
        longint u, s;
        if (is_sub) begin
            u = longint'(x) - longint'(y) - longint'(1 - int'(ci));
            s = longint'($signed(x)) - longint'($signed(y)) - longint'(1 - int'(ci));
            c = (u >= 0);
        end else begin
            u = longint'(x) + longint'(y) + longint'(ci);
            s = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
            c = u[32];
        end
        f = u[31:0];
        v = (s > SMAX) || (s < SMIN);
    endfunction

    // Sequential architectural model: ops execute strictly one after another.
    function automatic res_t model(input op_t o);
        logic [31:0] d, f;
        logic        c, v, cf, sets;
        int          n;
        res_t        r;
        cf = m_flags[1];
        d  = o.data;
        c  = cf;
        v  = m_flags[0];
        n  = (o.sh <= 3) ? int'(o.amt) : ((o.sh == 4) ? 1 : 0);
        for (int i = 0; i < n; i++) begin
            case (o.sh)
                3'd0:    begin c = d[31]; d = {d[30:0], 1'b0}; end
                3'd1:    begin c = d[0];  d = {1'b0, d[31:1]}; end
                3'd2:    begin c = d[0];  d = {d[31], d[31:1]}; end
                3'd3:    begin c = d[0];  d = {d[0], d[31:1]}; end
                default: begin c = d[0];  d = {cf, d[31:1]}; end
            endcase
        end
        f = 32'h0;
        case (o.alu)
            4'h0, 4'h8: f = o.a & d;
            4'h1, 4'h9: f = o.a ^ d;
            4'h2, 4'hA: arith(o.a, d, 1'b1, 1'b1, f, c, v);
            4'h3:       arith(d, o.a, 1'b1, 1'b1, f, c, v);
            4'h4, 4'hB: arith(o.a, d, 1'b0, 1'b0, f, c, v);
            4'h5:       arith(o.a, d, cf, 1'b0, f, c, v);
            4'h6:       arith(o.a, d, cf, 1'b1, f, c, v);
            4'h7:       arith(d, o.a, cf, 1'b1, f, c, v);
            4'hC:       f = o.a | d;
            4'hD:       f = d;
            4'hE:       f = o.a & ~d;
            default:    f = ~d;
        endcase
        sets = o.s || (o.alu >= 4'h8 && o.alu <= 4'hB);
        if (sets) m_flags = {f[31], (f == 32'h0), c, v};
        r.f    = f;
        r.nzcv = m_flags;
        r.wr   = !(o.alu >= 4'h8 && o.alu <= 4'hB);
        return r;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int  k;
        o.a    = $urandom();
        o.data = ($urandom_range(0, 4) == 0) ? 32'h80000001 : 32'($urandom());
        k      = $urandom_range(0, 3);
        o.amt  = (k == 0) ? 8'd0 : (k == 1) ? 8'($urandom_range(1, 31))
               : (k == 2) ? 8'($urandom_range(31, 33)) : 8'($urandom_range(0, 255));
        o.sh   = 3'($urandom_range(0, 7));
        o.alu  = 4'($urandom_range(0, 15));
        o.s    = 1'($urandom_range(0, 1));
        return o;
    endfunction

    // One clock: drive, sample at the falling edge, score, then advance past the rising edge.
    task automatic step(input bit send, input op_t op, input bit rdy, output bit fired, output bit ov);
        in_valid   = send;
        in_a       = op.a;
        in_data    = op.data;
        in_amt     = op.amt;
        in_shft_op = op.sh;
        in_alu_op  = op.alu;
        in_s       = op.s;
        out_ready  = rdy;
        @(negedge clk);
        ov    = out_valid;
        fired = in_valid && in_ready;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 64'd1, 64'd0);
            end else begin
                check("out_f", 64'(out_f), 64'(exp_q[0].f));
                check("out_nzcv", 64'(out_nzcv), 64'(exp_q[0].nzcv));
                check("out_wr", 64'(out_wr), 64'(exp_q[0].wr));
                check("flags_vs_s2", 64'(flags), 64'(exp_q[0].nzcv));
                if (out_ready) begin
                    last_f    = out_f;
                    last_nzcv = out_nzcv;
                    last_wr   = out_wr;
                    void'(exp_q.pop_front());
                end
            end
        end
        if (fired) exp_q.push_back(model(op));
        @(posedge clk);
        #1;
    endtask

    task automatic send_op(input op_t op);
        bit fired, ov;
        fired = 1'b0;
        for (int i = 0; i < 50 && !fired; i++) step(1'b1, op, 1'b1, fired, ov);
        if (!fired) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        bit fired, ov;
        op_t idle;
        idle = '0;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1'b0, idle, 1'b1, fired, ov);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit  fired, ov;
        op_t o, idle;
        op_t bp[3];
        int  acc;

        idle = '0;
        tbl[0]  = '{mk(32'h7FFFFFFF, 32'h1, 8'd0, 3'd0, 4'h4, 1'b1), 32'h80000000, 4'b1001, 1'b1};
        tbl[1]  = '{mk(32'h5, 32'h5, 8'd0, 3'd0, 4'h2, 1'b1), 32'h0, 4'b0110, 1'b1};
        tbl[2]  = '{mk(32'h0, 32'h80000000, 8'd32, 3'd1, 4'hD, 1'b1), 32'h0, 4'b0110, 1'b1};
        tbl[3]  = '{mk(32'h0, 32'h80000000, 8'd200, 3'd2, 4'hD, 1'b1), 32'hFFFFFFFF, 4'b1010, 1'b1};
        tbl[4]  = '{mk(32'h0, 32'h80000001, 8'd64, 3'd3, 4'hD, 1'b1), 32'h80000001, 4'b1010, 1'b1};
        tbl[5]  = '{mk(32'h0, 32'h1, 8'd0, 3'd0, 4'hA, 1'b0), 32'hFFFFFFFF, 4'b1000, 1'b0};
        tbl[6]  = '{mk(32'h0, 32'h2, 8'd0, 3'd4, 4'hD, 1'b1), 32'h1, 4'b0000, 1'b1};
        tbl[7]  = '{mk(32'hFFFFFFFF, 32'h1, 8'd0, 3'd0, 4'h4, 1'b1), 32'h0, 4'b0110, 1'b1};
        tbl[8]  = '{mk(32'h1, 32'h1, 8'd0, 3'd0, 4'h5, 1'b1), 32'h3, 4'b0000, 1'b1};
        tbl[9]  = '{mk(32'hFF, 32'h0F, 8'd0, 3'd0, 4'hE, 1'b0), 32'hF0, 4'b0000, 1'b1};
        tbl[10] = '{mk(32'h0, 32'h80000000, 8'd1, 3'd0, 4'hD, 1'b1), 32'h0, 4'b0110, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_data = '0;
        in_amt = '0; in_shft_op = '0; in_alu_op = '0; in_s = 1'b0;
        m_flags = 4'h0;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_f", 64'(out_f), 64'd0);
        check("rst_out_nzcv", 64'(out_nzcv), 64'd0);
        check("rst_out_wr", 64'(out_wr), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            send_op(tbl[i].op);
            drain();
            check($sformatf("tbl%0d_f", i), 64'(last_f), 64'(tbl[i].f));
            check($sformatf("tbl%0d_nzcv", i), 64'(last_nzcv), 64'(tbl[i].nzcv));
            check($sformatf("tbl%0d_wr", i), 64'(last_wr), 64'(tbl[i].wr));
        end

        // Carry hazard: CMP clears C, RRX right behind it must see that C.
        send_op(tbl[5].op);
        step(1'b1, tbl[6].op, 1'b1, fired, ov);
`ifdef ALU_SHIFT_PIPE_CF_FWD_EN
        check("hazard_no_stall", 64'(fired), 64'd1);
`else
        check("hazard_stall", 64'(fired), 64'd0);
        step(1'b1, tbl[6].op, 1'b1, fired, ov);
        check("hazard_one_cycle", 64'(fired), 64'd1);
`endif
        drain();
        check("hazard_f", 64'(last_f), 64'h1);
        check("hazard_nzcv", 64'(last_nzcv), 64'b0000);

        // Backpressure: three ops offered while out_ready stays low for 4 cycles.
        bp[0] = mk(32'h1, 32'h2, 8'd1, 3'd1, 4'h4, 1'b1);
        bp[1] = mk(32'h0, 32'h2, 8'd1, 3'd1, 4'h2, 1'b1);
        bp[2] = mk(32'h0, 32'h2, 8'd1, 3'd1, 4'hD, 1'b1);
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, bp[acc], 1'b0, fired, ov);
            if (fired) acc++;
        end
        check("bp_accepted", 64'(acc), 64'd2);
        while (acc < 3) begin
            send_op(bp[acc]);
            acc++;
        end
        drain();

        // Reset mid-stream with two ops in flight.
        step(1'b1, bp[1], 1'b0, fired, ov);
        step(1'b1, bp[0], 1'b0, fired, ov);
        in_valid = 1'b0;
        #2;
        check("pre_rst_flags", 64'(flags), 64'b1000);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_flags", 64'(flags), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        m_flags = 4'h0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        step(1'b1, tbl[7].op, 1'b1, fired, ov);
        check("lat_accept", 64'(fired), 64'd1);
        step(1'b0, idle, 1'b1, fired, ov);
        check("lat_k", 64'(ov), 64'd0);
        step(1'b0, idle, 1'b1, fired, ov);
        check("lat_k1", 64'(ov), 64'd1);
        drain();

        // Randomized traffic with random stalls on both sides.
        o = rand_op();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, o, $urandom_range(0, 3) != 0, fired, ov);
            if (fired) o = rand_op();
        end
        drain();
        check("final_queue", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_shift_pipe.md
# alu_shift_pipe

Parametrised, two-stage pipelined successor to the combinational ALU/barrel-shifter pair. Stage 1 shifts the second operand. Stage 2 runs the ARM data-processing operation and commits an internal NZCV flag register. Operands enter and results leave over valid/ready handshakes with full backpressure. A carry-flag hazard between back-to-back operations is either stalled or forwarded, depending on configuration.

## Interface
- WIDTH, 32: datapath width; power of two, 8..64.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- in_a  in  WIDTH  first ALU operand (Rn).
- in_data  in  WIDTH  shifter data (Rm / immediate).
- in_amt  in  8  shift amount (low byte of Rs or immediate).
- in_shft_op  in  3  0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 RRX, 5..7 pass-through.
- in_alu_op  in  4  ARM encoding: AND EOR SUB RSB ADD ADC SBC RSC TST TEQ CMP CMN ORR MOV BIC MVN (0..F).
- in_s  in  1  set-flags request.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_f  out  WIDTH  ALU result.
- out_nzcv  out  4  flags after this operation.
- out_wr  out  1  result is to be written back; 0 for ops 8..B.
- flags  out  4  architectural NZCV register, {N,Z,C,V}.

## Operation
- Shifter, stage 1. The amount is the full 8-bit in_amt. The shifter carry-in is CF.
  - Amount 0 with op 0..3: out = data, carry = CF.
  - LSL n: for n < W, carry = data[W-n]. For n == W, out = 0, carry = data[0]. For n > W, out = 0, carry = 0.
  - LSR n: for n < W, carry = data[n-1]. For n == W, out = 0, carry = data[W-1]. For n > W, out = 0, carry = 0.
  - ASR n: for n >= W, out = all sign bits, carry = sign.
  - ROR n: rotate by n mod W, carry = out[W-1]. When n mod W == 0 and n != 0, out = data, carry = data[W-1].
  - RRX: out = {CF, data[W-1:1]}, carry = data[0]. in_amt is ignored.
  - Ops 5..7: out = data, carry = CF.
- ALU, at the stage 1 to stage 2 transfer.
  - Arithmetic ops (SUB RSB ADD ADC SBC RSC CMP CMN) use W+1-bit sums.
  - C is carry-out for arithmetic ops. For subtract-type ops, C = NOT borrow.
  - V is signed overflow.
  - ADC, SBC and RSC take CF from the flags register at transfer time.
  - Logical ops: C = shifter carry, V = flags V unchanged.
  - N = F[W-1]. Z = (F == 0).
- Flag commit.
  - Ops 8..B always set flags, regardless of in_s. Other ops set flags only when in_s = 1.
  - The flags register is written on the same edge the operation loads stage 2.
  - When an operation does not set flags, out_nzcv equals the unchanged flags.
- Pipeline control.
  - s2_en = !out_valid || out_ready.
  - Stage 1 advances when s1_valid && s2_en.
  - in_ready = (!s1_valid || s2_en) && !hazard.
- Hazard.
  - An incoming op "uses CF" when its shift op is 4, or 5..7, or 0..3 with in_amt == 0.
  - hazard = s1_valid && (stage-1 op sets flags) && (incoming op uses CF) && CF_FWD not compiled.

## Timing
- Reset values: in_ready 1; out_valid 0; out_f 0; out_nzcv 0; out_wr 0; flags 0; all internal valids 0.
- Latency: an op accepted at edge k is presented with out_valid = 1 after edge k+1.
- Throughput: one op per cycle when there is no stall and no hazard.
- Under backpressure, out_* and flags hold stable while out_valid && !out_ready.
- A hazard stall lasts exactly one cycle when out_ready = 1.
- Reset asserted mid-operation drops every in-flight op immediately. No flag commit occurs.

## Configuration
- ALU_SHIFT_PIPE_CF_FWD_EN defined:
  - The shifter's CF is taken from the ALU C output of the stage-1 op when that op is valid and sets flags. Otherwise it comes from the flags register.
  - hazard is held at 0.
- Not defined: the shifter reads the flags register only, and the hazard stall applies.
- Results are identical in both builds; only cycle count differs.

## Test plan
- Reset check: assert rst mid-stream.
  - Required: out_valid = 0, flags = 0 and in_ready = 1 asynchronously.
  - First op after release appears 2 cycles after acceptance.
- ADD with overflow, WIDTH = 32: a = 0x7FFFFFFF, data = 1, LSL 0, S = 1.
  - Required: F = 0x80000000, NZCV = 1001.
- SUB equality, WIDTH = 32: a = 5, data = 5, S = 1.
  - Required: F = 0, NZCV = 0110.
- Shift edge cases with MOV, S = 1, WIDTH = 32.
  - LSR #32 of 0x80000000: F = 0, C = 1.
  - ASR #200 of 0x80000000: F = 0xFFFFFFFF, C = 1.
  - ROR #64 of 0x80000001: F unchanged, C = 1.
- Carry hazard: CMP 0,1 (sets C = 0), then back-to-back MOV RRX of 0x2, S = 1.
  - Required result: F = 0x1, C = 0.
  - Without the macro: in_ready = 0 for one cycle.
  - With the macro: no stall.
- Backpressure: 3 ops issued with out_ready held 0 for 4 cycles.
  - Required: at most 2 ops accepted, out_* stable, flags committed only on stage-2 load.
  - Order preserved after release.
